em604_divisor_n: RTL

EM604_DIVISOR_N -- requirements
Module: em604_divisor_n

---
 rtl/em604_divisor_n_pkg.sv | 20 ++
 rtl/em604_divisor_n_if.sv | 35 +++
 rtl/em604_divisor_n_step.sv | 35 +++
 rtl/em604_divisor_n.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/em604_divisor_n_pkg.sv
// ---------------------------------------------------------------------------
// em604_div_pkg
// Shared definitions for the em604 restoring divider slice: FSM state
// encoding and the default operand width.
// ---------------------------------------------------------------------------
package em604_div_pkg;

    // Default operand / quotient / remainder width.
    localparam int WIDTH_DEF = 8;

    // Divider FSM states. CALC and FIX differ from LOAD/IDLE in one bit, so
    // the encoding follows a Gray-like IDLE->LOAD->CALC->FIX walk.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CALC = 2'b11,
        FIX  = 2'b10
    } div_state_t;

endpackage : em604_div_pkg

// File: rtl/em604_divisor_n_if.sv
// ---------------------------------------------------------------------------
// em604_divisor_n_if
// Request/result bundle of the em604 divider.
//   A, B      : dividend / divisor (WIDTH)
//   sinal     : 1 = two's-complement operands, 0 = unsigned
//   ini_div   : start request, level-sampled
//   Q, R      : quotient / remainder (WIDTH), registered
//   ocupado   : busy
//   fim_div   : one-cycle done pulse
//   erro_div  : divide-by-zero flag
// master drives the request side, slave is the divider.
// ---------------------------------------------------------------------------
interface em604_divisor_n_if #(
    parameter int WIDTH = em604_div_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sinal;
    logic             ini_div;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             ocupado;
    logic             fim_div;
    logic             erro_div;

    modport master (
        output A, B, sinal, ini_div,
        input  Q, R, ocupado, fim_div, erro_div
    );

    modport slave (
        input  A, B, sinal, ini_div,
        output Q, R, ocupado, fim_div, erro_div
    );
endinterface : em604_divisor_n_if

// File: rtl/em604_divisor_n_step.sv
// ---------------------------------------------------------------------------
// em604_div_step
// One combinational restoring-division step on magnitudes.
//   i_p   : partial remainder P (WIDTH+1)
//   i_dvd : dividend / quotient shift register (WIDTH)
//   i_dvs : divisor magnitude (WIDTH)
//   o_p   : next partial remainder
//   o_dvd : next dividend/quotient register (new quotient bit in LSB)
// ---------------------------------------------------------------------------
module em604_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_p,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_p,
    output logic [WIDTH-1:0] o_dvd
);
    // {P, dividend} shifted left by one, upper half only; one extra bit so
    // the subtraction borrow shows up in the MSB.
    logic [WIDTH+1:0] w_p_sh;
    logic [WIDTH+1:0] w_diff;

    // Shift, trial-subtract and restore.
    always_comb begin
        w_p_sh = {i_p, i_dvd[WIDTH-1]};
        w_diff = w_p_sh - {2'b00, i_dvs};
        if (w_diff[WIDTH+1] == 1'b0) begin
            o_p = w_diff[WIDTH:0];
        end else begin
            o_p = w_p_sh[WIDTH:0];
        end
        o_dvd = {i_dvd[WIDTH-2:0], ~w_diff[WIDTH+1]};
    end
endmodule : em604_div_step

// File: rtl/em604_divisor_n.sv
// ---------------------------------------------------------------------------
// em604_divisor_n
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per
// clock. Start with ini_div in IDLE; result appears with fim_div.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : em604_divisor_n_if.slave (A, B, sinal, ini_div -> Q, R,
//            ocupado, fim_div, erro_div)
// Parameters: WIDTH (4..32), SIGNED_EN (0 forces unsigned division).
// ---------------------------------------------------------------------------
module em604_divisor_n
    import em604_div_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    em604_divisor_n_if.slave   bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    div_state_t        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sinal;
    logic [WIDTH-1:0]  r_dvd;
    logic [WIDTH-1:0]  r_dvs;
    logic [WIDTH:0]    r_p;
    logic [CW-1:0]     r_cnt;
    logic              r_div0;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_r;
    logic              r_ocupado;
    logic              r_fim;
    logic              r_erro;

    logic              w_signed;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic              w_neg_q;
    logic              w_neg_r;
    logic              w_b_zero;
    logic [WIDTH:0]    w_p_next;
    logic [WIDTH-1:0]  w_dvd_next;

    // Operand magnitudes and result sign decisions from the captured request.
    always_comb begin
        w_signed = (SIGNED_EN != 0) && r_sinal;
        w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
        w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
        // Quotient negative when signs differ; remainder follows the dividend.
        w_neg_q  = w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        w_neg_r  = w_signed && r_a[WIDTH-1];
        w_b_zero = (r_b == {WIDTH{1'b0}});
    end

    em604_div_step #(.WIDTH(WIDTH)) u_step (
        .i_p   (r_p),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_p   (w_p_next),
        .o_dvd (w_dvd_next)
    );

    // Divider FSM with registered results and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_sinal   <= 1'b0;
            r_dvd     <= {WIDTH{1'b0}};
            r_dvs     <= {WIDTH{1'b0}};
            r_p       <= {(WIDTH+1){1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_div0    <= 1'b0;
            r_q       <= {WIDTH{1'b0}};
            r_r       <= {WIDTH{1'b0}};
            r_ocupado <= 1'b0;
            r_fim     <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.ini_div) begin
                        r_a       <= bus.A;
                        r_b       <= bus.B;
                        r_sinal   <= bus.sinal;
                        r_ocupado <= 1'b1;
                        r_state   <= LOAD;
                    end else begin
                        r_ocupado <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                LOAD: begin
                    r_dvd <= w_mag_a;
                    r_dvs <= w_mag_b;
                    r_p   <= {(WIDTH+1){1'b0}};
                    r_cnt <= {CW{1'b0}};
                    if (w_b_zero) begin
                        r_div0  <= 1'b1;
                        r_state <= FIX;
                    end else begin
                        r_div0  <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_p_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end else begin
                        r_state <= CALC;
                    end
                end
                FIX: begin
                    if (r_div0) begin
                        r_q    <= {WIDTH{1'b1}};
                        r_r    <= r_a;
                        r_erro <= 1'b1;
                    end else begin
                        // Negating the magnitude lets -2^(W-1)/-1 wrap to itself.
                        r_q    <= w_neg_q ? -r_dvd : r_dvd;
                        r_r    <= w_neg_r ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
                        r_erro <= 1'b0;
                    end
                    r_fim     <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.Q        = r_q;
    assign bus.R        = r_r;
    assign bus.ocupado  = r_ocupado;
    assign bus.fim_div  = r_fim;
    assign bus.erro_div = r_erro;

endmodule : em604_divisor_n
